jtcps1_obj_draw: RTL

- Downstream consumer of the object line table.
- Once per scan line it walks the line table's 128 four-word entries and fetches 16-pixel tile rows from graphics ROM.
- It decodes the 4bpp planar data and writes palette/colour pixels into the object line buffer that feeds the colour mixer.
- Processing stops at the first fill entry (0xFFFF) or after 128 entries.

---
 rtl/jtcps1_obj_draw.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/jtcps1_obj_draw.sv
// rtl/jtcps1_obj_draw.sv - object line renderer: walks the line table, fetches tile rows, writes the line buffer
//
// Purpose:
//   Once per scan line, walks up to MAXENTRY four-word entries of the object line table.
//   For each entry it fetches two 8-pixel halves of a 4bpp planar tile row from graphics ROM.
//   Every non-transparent pixel is written into the object line buffer.
//   The scan ends at the first 0xFFFF entry or after MAXENTRY entries.
//
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   start          one-cycle pulse at line start; restarts the scan even while busy
//   busy           scan in progress
//   line_addr      line table address {entry, word}
//   line_data      line table word for the current line_addr, sampled one clk later
//   rom_addr       ROM word address {code, vsub, half}
//   rom_cs         ROM request, held until rom_ok
//   rom_ok         rom_data valid
//   rom_data       four bitplanes, plane0 in [7:0] through plane3 in [31:24]
//   buf_addr       line buffer pixel x
//   buf_data       {pal, colour}
//   buf_wr         line buffer write strobe
module jtcps1_obj_draw #(
  parameter int         MAXENTRY = 128,
  parameter logic [3:0] TRANSP   = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic [8:0]  line_addr,
  input  logic [15:0] line_data,
  output logic [20:0] rom_addr,
  output logic        rom_cs,
  input  logic        rom_ok,
  input  logic [31:0] rom_data,
  output logic [8:0]  buf_addr,
  output logic [8:0]  buf_data,
  output logic        buf_wr
);

  typedef enum logic [3:0] {
    IDLE, RDW0, RDW1, RDW2, REQ, WAIT, DRAW, NEXT, DONE
  } state_t;

  state_t      state, state_nx;

  logic [6:0]  entry;
  logic [3:0]  vsub;
  logic        hflip;
  logic [4:0]  pal;
  logic [15:0] code;
  logic [8:0]  xpos;
  logic        half;     // ROM half currently requested/drawn
  logic        second;   // 0 while drawing the first half of the entry, 1 for the second
  logic [2:0]  pix;
  logic [31:0] pixels;   // latched tile row half
  logic        last_entry;
  logic [2:0]  bsel;
  logic [3:0]  colour;

  assign last_entry = (entry == 7'(MAXENTRY - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE) && (state != DONE);
    rom_cs   = 1'b0;
    buf_wr   = 1'b0;
    buf_addr = 9'd0;
    buf_data = 9'd0;
    // Without hflip the leftmost pixel comes from bit 7 of each plane byte.
    bsel     = hflip ? pix : 3'd7 - pix;
    colour   = {pixels[{2'b11, bsel}], pixels[{2'b10, bsel}],
                pixels[{2'b01, bsel}], pixels[{2'b00, bsel}]};

    case (state)
      IDLE: ;
      RDW0: state_nx = (line_data == 16'hFFFF) ? DONE : RDW1;
      RDW1: state_nx = RDW2;
      RDW2: state_nx = REQ;
      REQ:  state_nx = WAIT;
      WAIT: begin
        rom_cs = 1'b1;
        if (rom_ok) state_nx = DRAW;
      end
      DRAW: begin
        buf_addr = xpos + {5'd0, second, pix};  // wraps at 9 bits by design
        buf_data = {pal, colour};
        buf_wr   = (colour != TRANSP);
        if (pix == 3'd7) state_nx = second ? NEXT : REQ;
      end
      NEXT: state_nx = last_entry ? DONE : RDW0;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // A start pulse aborts whatever is in flight, including a pending ROM request.
    if (start) begin
      state_nx = RDW0;
      rom_cs   = 1'b0;
      buf_wr   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry     <= 7'd0;
      line_addr <= 9'd0;
      rom_addr  <= 21'd0;
      vsub      <= 4'd0;
      hflip     <= 1'b0;
      pal       <= 5'd0;
      code      <= 16'd0;
      xpos      <= 9'd0;
      half      <= 1'b0;
      second    <= 1'b0;
      pix       <= 3'd0;
      pixels    <= 32'd0;
    end else if (start) begin
      entry     <= 7'd0;
      line_addr <= 9'd0;
    end else begin
      case (state)
        RDW0: if (line_data != 16'hFFFF) begin
          vsub      <= line_data[11:8];
          hflip     <= line_data[5];
          pal       <= line_data[4:0];
          line_addr <= {entry, 2'd1};
        end
        RDW1: begin
          code      <= line_data;
          line_addr <= {entry, 2'd2};
        end
        RDW2: begin
          xpos   <= line_data[8:0];
          half   <= hflip;         // mirrored tiles start with the right-hand half
          second <= 1'b0;
        end
        REQ:  rom_addr <= {code, vsub, half};
        WAIT: if (rom_ok) begin
          pixels <= rom_data;
          pix    <= 3'd0;
        end
        DRAW: begin
          pix <= pix + 3'd1;
          if (pix == 3'd7 && !second) begin
            half   <= ~half;
            second <= 1'b1;
          end
        end
        NEXT: if (!last_entry) begin
          entry     <= entry + 7'd1;
          line_addr <= {entry + 7'd1, 2'd0};
        end
        default: ;
      endcase
    end
  end

endmodule
